pwm_recon_ctrl: RTL and testbench

PWM_RECON_CTRL -- requirements
Module: pwm_recon_ctrl

---
 rtl/pwm_recon_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pwm_recon_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_recon_ctrl.sv
// pwm_recon_ctrl
//   Measures an incoming PWM stream, locks onto it once a valid period has
//   been observed, and drives a registered reconstruction of the waveform.
//   When the input goes quiet while locked, the block can keep producing
//   the last measured waveform for a bounded number of periods (holdover).
//
// Build option:
//   PWM_RECON_HOLDOVER_EN  defined   : HOLDOVER state with phase generator.
//                          undefined : a locked timeout drops straight to IDLE
//                                      and 'lost' pulses for one cycle.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   pwm_in     in   asynchronous PWM input
//   recon_out  out  registered reconstructed PWM
//   locked     out  high while in LOCKED
//   lost       out  high while in HOLDOVER (or 1-cycle timeout pulse)
//   period_q   out  last measured period in clk cycles
//   high_q     out  last measured high time in clk cycles
//   state_dbg  out  current FSM state (IDLE=0 MEASURE=1 LOCKED=2 HOLDOVER=3)

module pwm_recon_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MIN_PERIOD = 16,
  parameter int HOLD_MAX   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic             recon_out,
  output logic             locked,
  output logic             lost,
  output logic [CNT_W-1:0] period_q,
  output logic [CNT_W-1:0] high_q,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  // Parameter sanity: a zero holdover length or a period shorter than the
  // edge detector can resolve makes no sense.
  if (MIN_PERIOD < 2 || HOLD_MAX < 1) begin : g_param_check
    $error("pwm_recon_ctrl: MIN_PERIOD must be >= 2 and HOLD_MAX >= 1");
  end

  state_t state, state_nxt;

  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt;
  logic             cnt_sat;
  logic             fall_seen;
  logic [CNT_W:0]   tmo_lim;
  logic             timeout;
  logic             recon_nxt;
  logic             cap_period;

  // s3 is only the edge-detect history; a single-bit compare can never flag
  // rise and fall together.
  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign cnt_sat = &cnt;

  // Timeout at 1.25 x period, evaluated one bit wider so it cannot wrap.
  assign tmo_lim = {1'b0, period_q} + {3'b000, period_q[CNT_W-1:2]};
  assign timeout = ({1'b0, cnt} == tmo_lim);

`ifdef PWM_RECON_HOLDOVER_EN
  localparam int HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] ph, ph_nxt;
  logic [HC_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic             ph_wrap;

  assign ph_wrap = (ph == period_q);
`else
  logic lost_q;
`endif

  always_comb begin
    state_nxt  = state;
    recon_nxt  = s2;
    cap_period = 1'b0;
`ifdef PWM_RECON_HOLDOVER_EN
    ph_nxt       = '0;
    hold_cnt_nxt = '0;
`endif
    case (state)
      IDLE: begin
        if (rise) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          cap_period = 1'b1;
          if (cnt >= MIN_P && fall_seen) state_nxt = LOCKED;
        end else if (cnt_sat) begin
          state_nxt = IDLE;
        end
      end
      LOCKED: begin
        // A rise always wins over a coincident timeout.
        if (rise) begin
          if (cnt < MIN_P) state_nxt = MEASURE;  // glitch: keep old period
          else             cap_period = 1'b1;
        end else if (timeout) begin
`ifdef PWM_RECON_HOLDOVER_EN
          state_nxt = HOLDOVER;
          ph_nxt    = ONE;
          recon_nxt = (ONE <= high_q);
`else
          state_nxt = IDLE;
          recon_nxt = 1'b0;
`endif
        end
      end
      HOLDOVER: begin
`ifdef PWM_RECON_HOLDOVER_EN
        if (rise) begin
          state_nxt = MEASURE;
        end else if (ph_wrap) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt = IDLE;
            recon_nxt = 1'b0;
          end else begin
            ph_nxt       = ONE;
            hold_cnt_nxt = hold_cnt + HC_W'(1);
            recon_nxt    = (ONE <= high_q);
          end
        end else begin
          ph_nxt       = ph + ONE;
          hold_cnt_nxt = hold_cnt;
          recon_nxt    = (ph_nxt <= high_q);
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
      fall_seen <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      recon_out <= 1'b0;
`ifdef PWM_RECON_HOLDOVER_EN
      ph        <= '0;
      hold_cnt  <= '0;
`else
      lost_q    <= 1'b0;
`endif
    end else begin
      s1        <= pwm_in;
      s2        <= s1;
      s3        <= s2;
      state     <= state_nxt;
      recon_out <= recon_nxt;
      if (rise)          cnt <= ONE;
      else if (!cnt_sat) cnt <= cnt + ONE;
      if (rise)      fall_seen <= 1'b0;
      else if (fall) fall_seen <= 1'b1;
      if (fall)       high_q   <= cnt;
      if (cap_period) period_q <= cnt;
`ifdef PWM_RECON_HOLDOVER_EN
      ph        <= ph_nxt;
      hold_cnt  <= hold_cnt_nxt;
`else
      lost_q    <= (state == LOCKED) && !rise && timeout;
`endif
    end
  end

  assign locked    = (state == LOCKED);
  assign state_dbg = state;
`ifdef PWM_RECON_HOLDOVER_EN
  assign lost      = (state == HOLDOVER);
`else
  assign lost      = lost_q;
`endif

endmodule

// File: tb/tb_pwm_recon_ctrl.sv
// Testbench for pwm_recon_ctrl: table of PWM patterns with end-of-pattern
// expectations, a recon_out mirror scoreboard (3-cycle latency), plus
// hand-written holdover / timeout, glitch and asynchronous reset sequences.

module tb_pwm_recon_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pwm_in;
  logic             recon_out;
  logic             locked;
  logic             lost;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic [1:0]       state_dbg;

  pwm_recon_ctrl #(.CNT_W(CNT_W), .MIN_PERIOD(16), .HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .recon_out (recon_out),
    .locked    (locked),
    .lost      (lost),
    .period_q  (period_q),
    .high_q    (high_q),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  logic [0:0] exp_q[$];
  logic       chk_mirror;
  int         last_rise;
  logic       lock_arm;
  int         lock_cyc;
  int         rise_cnt;
  int         rise2_cyc;
  int         ent;

  typedef struct {
    int         period;
    int         high;
    int         n;
    int         exp_period;
    int         exp_high;
    logic       exp_locked;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // One clock: sample just after the edge, compare recon_out against the
  // input driven three steps earlier, then drive the next input value.
  task automatic step(input logic p);
    logic [0:0] e;
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    if (chk_mirror) check("recon_mirror", 32'(recon_out), 32'(e));
    if (lock_arm && locked) begin
      lock_cyc = cyc;
      lock_arm = 1'b0;
    end
    pwm_in = p;
    exp_q.push_back(p);
  endtask

  task automatic restart_queue();
    exp_q.delete();
    repeat (3) exp_q.push_back(1'b0);
  endtask

  task automatic run_periods(input int period, input int high, input int n);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < period; c++) begin
        if (c == 0) begin
          last_rise = cyc + 1;
          rise_cnt++;
          if (rise_cnt == 2) rise2_cyc = cyc + 1;
        end
        step(c < high);
      end
    end
  endtask

  // Keep the input low until the step just before the locked timeout fires
  // (rise detected 3 steps after drive, timeout 125 cycles later).
  task automatic hold_to_entry();
    chk_mirror = 1'b1;
    while (cyc < last_rise + 127) step(1'b0);
    chk_mirror = 1'b0;
    ent = last_rise + 128;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_recon"},    32'(recon_out), 32'd0);
    check({tag, "_locked"},   32'(locked),    32'd0);
    check({tag, "_lost"},     32'(lost),      32'd0);
    check({tag, "_period_q"}, 32'(period_q),  32'd0);
    check({tag, "_high_q"},   32'(high_q),    32'd0);
    check({tag, "_state"},    32'(state_dbg), 32'd0);
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    @(posedge clk);
    @(negedge clk);
    pwm_in = 1'b0;
    rst_n  = 1'b1;
    restart_queue();
    chk_mirror = 1'b1;
    repeat (4) step(1'b0);
    check({tag, "_idle_after_release"}, 32'(state_dbg), 32'd0);
  endtask

  task automatic relock_from_reset(input string tag);
    lock_arm = 1'b1;
    lock_cyc = -1;
    rise_cnt = 0;
    run_periods(100, 30, 3);
    check({tag, "_lock_cycle"}, 32'(lock_cyc), 32'(rise2_cyc + 3));
    check({tag, "_period_q"},   32'(period_q), 32'd100);
    check({tag, "_high_q"},     32'(high_q),   32'd30);
    check({tag, "_locked"},     32'(locked),   32'd1);
  endtask

  initial begin
    vecs[0] = '{100, 30, 3, 100, 30, 1'b1, 2'd2};
    vecs[1] = '{ 64, 16, 3,  64, 16, 1'b1, 2'd2};
    vecs[2] = '{ 40, 35, 3,  40, 35, 1'b1, 2'd2};
    vecs[3] = '{ 16,  4, 3,  16,  4, 1'b1, 2'd2};  // exactly the minimum
    vecs[4] = '{ 15,  5, 3,  15,  5, 1'b0, 2'd1};  // too short: drop out
    vecs[5] = '{100, 30, 3, 100, 30, 1'b1, 2'd2};

    // ---------------- reset ----------------
    rst_n      = 1'b0;
    pwm_in     = 1'b0;
    chk_mirror = 1'b0;
    lock_arm   = 1'b0;
    lock_cyc   = -1;
    rise_cnt   = 0;
    rise2_cyc  = 0;
    last_rise  = 0;
    ent        = 0;
    restart_queue();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n      = 1'b1;
    chk_mirror = 1'b1;
    repeat (5) step(1'b0);
    check("idle_after_reset", 32'(state_dbg), 32'd0);

    // ---------------- table-driven patterns ----------------
    lock_arm = 1'b1;
    for (int v = 0; v < 6; v++) begin
      run_periods(vecs[v].period, vecs[v].high, vecs[v].n);
      check("vec_period_q", 32'(period_q),  32'(vecs[v].exp_period));
      check("vec_high_q",   32'(high_q),    32'(vecs[v].exp_high));
      check("vec_locked",   32'(locked),    32'(vecs[v].exp_locked));
      check("vec_state",    32'(state_dbg), 32'(vecs[v].exp_state));
      check("vec_lost",     32'(lost),      32'd0);
    end
    check("first_lock_cycle", 32'(lock_cyc), 32'(rise2_cyc + 3));

    // ---------------- glitch while locked ----------------
    // Low dip of 5 cycles early in the high phase: the re-rise comes 13
    // cycles after the real rise, below the minimum period.
    last_rise = cyc + 1;
    for (int c = 0; c < 100; c++) begin
      step((c < 8) || (c >= 13 && c < 30));
      if (c == 16) begin
        check("glitch_state",    32'(state_dbg), 32'd1);
        check("glitch_locked",   32'(locked),    32'd0);
        check("glitch_period_q", 32'(period_q),  32'd100);
        check("glitch_high_q",   32'(high_q),    32'd8);
      end
    end
    run_periods(100, 30, 2);
    check("relock_locked",   32'(locked),   32'd1);
    check("relock_period_q", 32'(period_q), 32'd100);
    check("relock_high_q",   32'(high_q),   32'd30);

`ifdef PWM_RECON_HOLDOVER_EN
    // ---------------- full holdover then IDLE ----------------
    hold_to_entry();
    for (int i = 0; i <= 400; i++) begin
      step(1'b0);
      check("hold_lost",  32'(lost),      32'(i < 400));
      check("hold_recon", 32'(recon_out), 32'((i < 400) && ((i % 100) < 30)));
      if (i == 0) check("hold_entry_state", 32'(state_dbg), 32'd3);
    end
    check("hold_exit_state",  32'(state_dbg), 32'd0);
    check("hold_exit_locked", 32'(locked),    32'd0);
    chk_mirror = 1'b1;
    run_periods(100, 30, 3);
    check("relock2_locked", 32'(locked), 32'd1);

    // ---------------- rise during holdover at ph = 50 ----------------
    hold_to_entry();
    for (int i = 0; i < 50; i++) begin
      if (i == 47) last_rise = cyc + 1;
      step(i >= 47);
      check("hold2_lost",  32'(lost),      32'd1);
      check("hold2_recon", 32'(recon_out), 32'(i < 30));
    end
    chk_mirror = 1'b1;
    for (int c = 3; c < 100; c++) begin
      step(c < 30);
      if (c == 3) begin
        check("hold_rise_state",    32'(state_dbg), 32'd1);
        check("hold_rise_lost",     32'(lost),      32'd0);
        check("hold_rise_recon",    32'(recon_out), 32'd1);
        check("hold_rise_period_q", 32'(period_q),  32'd100);
      end
    end
    run_periods(100, 30, 2);
    check("relock3_locked",   32'(locked),   32'd1);
    check("relock3_period_q", 32'(period_q), 32'd100);

    // ---------------- reset in the middle of holdover ----------------
    hold_to_entry();
    for (int i = 0; i <= 10; i++) step(1'b0);
    check("pre_reset_recon", 32'(recon_out), 32'd1);
    check("pre_reset_lost",  32'(lost),      32'd1);
    async_reset_check("mid_hold_reset");
`else
    // ---------------- locked timeout straight to IDLE ----------------
    hold_to_entry();
    step(1'b0);
    check("tmo_lost_pulse", 32'(lost),      32'd1);
    check("tmo_recon",      32'(recon_out), 32'd0);
    check("tmo_state",      32'(state_dbg), 32'd0);
    check("tmo_locked",     32'(locked),    32'd0);
    step(1'b0);
    check("tmo_lost_end",   32'(lost),      32'd0);
    chk_mirror = 1'b1;
    run_periods(100, 30, 3);
    check("relock2_locked", 32'(locked), 32'd1);

    // ---------------- reset in the middle of a high phase ----------------
    last_rise = cyc + 1;
    for (int c = 0; c < 10; c++) step(1'b1);
    check("pre_reset_recon",  32'(recon_out), 32'd1);
    check("pre_reset_locked", 32'(locked),    32'd1);
    async_reset_check("mid_lock_reset");
`endif

    // ---------------- full measure needed after reset ----------------
    relock_from_reset("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
